time_keeper: RTL



---
 rtl/time_keeper.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/time_keeper.sv
// Seconds-of-day time keeper with prescaled RUN tick and a three-button set mode.
// Optional alarm output is built only when TIME_KEEPER_ALARM_EN is defined.
module time_keeper #(
  parameter int CLK_FREQ_HZ   = 100000000,
  parameter int TICK_HZ       = 1,
  parameter int SECS_MAX      = 86399,
  parameter int SECS_W        = $clog2(SECS_MAX + 1),
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        buttons,
`ifdef TIME_KEEPER_ALARM_EN
  input  logic [SECS_W-1:0] alarm_secs,
  output logic              alarm,
`endif
  output logic [SECS_W-1:0] secs,
  output logic [1:0]        mode,
  output logic              tick
);

  localparam int DIV  = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
  localparam logic [SECS_W:0] SECS_TOP = (SECS_W + 1)'(SECS_MAX);
  localparam logic [SECS_W:0] SECS_MOD = (SECS_W + 1)'(SECS_MAX + 1);
  localparam logic [HW-1:0]   HOLD_V   = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0]   REP_V    = HW'(REPEAT_CYCLES);
  localparam logic [HW-1:0]   HOLD_ONE = HW'(1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } mode_t;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      RUN:      next_mode = SET_HOUR;
      SET_HOUR: next_mode = SET_MIN;
      SET_MIN:  next_mode = SET_SEC;
      SET_SEC:  next_mode = RUN;
      default:  next_mode = RUN;
    endcase
  endfunction

  mode_t             r_mode;
  logic [SECS_W-1:0] r_secs;
  logic              r_tick;
  logic [PW-1:0]     r_presc;
  logic [HW-1:0]     r_hold;
  logic              r_rep;
  logic [2:0]        r_btn_prev;
  logic              r_armed;

  logic [2:0]        w_rise;
  logic              w_one;
  logic              w_first;
  logic              w_repeat_due;
  logic [SECS_W:0]   w_step;
  logic [SECS_W:0]   w_secs_ext;
  logic [SECS_W:0]   w_inc_sum;
  logic [SECS_W:0]   w_inc;
  logic [SECS_W:0]   w_dec;
  logic [SECS_W-1:0] w_stepped;

  // Edge detection, step size and the modulo increment/decrement candidates.
  always_comb begin
    // r_armed masks the first sample after reset so a button held through reset gives no edge
    w_rise       = buttons & ~r_btn_prev & {3{r_armed}};
    w_one        = buttons[2] ^ buttons[0];
    w_first      = w_one & ((buttons[0] & w_rise[0]) | (buttons[2] & w_rise[2]));
    w_repeat_due = w_one & (r_hold != '0) &
                   ((~r_rep & (r_hold == HOLD_V)) | (r_rep & (r_hold == REP_V)));
    case (r_mode)
      SET_HOUR: w_step = (SECS_W + 1)'(3600);
      SET_MIN:  w_step = (SECS_W + 1)'(60);
      SET_SEC:  w_step = (SECS_W + 1)'(1);
      default:  w_step = '0;
    endcase
    w_secs_ext = {1'b0, r_secs};
    w_inc_sum  = w_secs_ext + w_step;
    if (w_inc_sum > SECS_TOP) begin
      w_inc = w_inc_sum - SECS_MOD;
    end else begin
      w_inc = w_inc_sum;
    end
    if (w_secs_ext < w_step) begin
      w_dec = w_secs_ext + SECS_MOD - w_step;
    end else begin
      w_dec = w_secs_ext - w_step;
    end
    if (buttons[0]) begin
      w_stepped = w_inc[SECS_W-1:0];
    end else begin
      w_stepped = w_dec[SECS_W-1:0];
    end
  end

  // Mode FSM, prescaler, seconds counter and auto-repeat hold counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode     <= RUN;
      r_secs     <= '0;
      r_tick     <= 1'b0;
      r_presc    <= '0;
      r_hold     <= '0;
      r_rep      <= 1'b0;
      r_btn_prev <= 3'b000;
      r_armed    <= 1'b0;
    end else begin
      r_btn_prev <= buttons;
      r_armed    <= 1'b1;
      r_tick     <= 1'b0;
      if (w_rise[1]) begin
        // a mode change pre-empts both a tick and a step in the same cycle
        r_mode  <= next_mode(r_mode);
        r_presc <= '0;
        r_hold  <= '0;
        r_rep   <= 1'b0;
      end else if (r_mode == RUN) begin
        r_hold <= '0;
        r_rep  <= 1'b0;
        if (r_presc == PRE_LAST) begin
          r_presc <= '0;
          r_tick  <= 1'b1;
          if (r_secs == SECS_TOP[SECS_W-1:0]) begin
            r_secs <= '0;
          end else begin
            r_secs <= r_secs + SECS_W'(1);
          end
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end else begin
        r_presc <= '0;
        if (!w_one) begin
          r_hold <= '0;
          r_rep  <= 1'b0;
        end else if (w_first || w_repeat_due) begin
          r_secs <= w_stepped;
          r_hold <= HOLD_ONE;
          r_rep  <= w_repeat_due;
        end else if (r_hold != '0) begin
          r_hold <= r_hold + HOLD_ONE;
        end else begin
          r_hold <= '0;
        end
      end
    end
  end

`ifdef TIME_KEEPER_ALARM_EN
  logic r_alarm;

  // Alarm fires the cycle after a RUN tick lands secs on the alarm value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alarm <= 1'b0;
    end else begin
      r_alarm <= r_tick && (r_secs == alarm_secs);
    end
  end

  assign alarm = r_alarm;
`endif

  assign secs = r_secs;
  assign mode = r_mode;
  assign tick = r_tick;

endmodule
